pnb_payload_dispatch: RTL and testbench
=======================================

// Module: pnb_payload_dispatch
// PURPOSE
//  Consumes payload/pvld words from the SPI protocol-analysis stage, buffers them in a small FIFO
//  and turns each into a register-bus transaction: write, or read plus response.
//  Read data returns as a response word for the SPI transmit path (dataout/vldout side).
//  All logic runs in the sck domain.
// PARAMETERS
//  ADDR_W       8    register address width; payload[39:32]
//  DATA_W       32   register data width; payload[31:0]
//  FIFO_DEPTH   4    command FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  255  bus-ack timeout in sck cycles (only with PNB_TIMEOUT_EN)
// PORTS
//  sck       in   1                clock, the single clock domain
//  rst       in   1                synchronous active-high reset
//  payload   in   1+ADDR_W+DATA_W  [40]=1 read/0 write, [39:32] addr, [31:0] wdata
//  pvld      in   1                payload valid, 1-cycle strobe, no backpressure
//  bus_req   out  1                bus request, held until bus_ack
//  bus_wr    out  1                1=write, 0=read; stable while bus_req
//  bus_addr  out  ADDR_W           bus address; stable while bus_req
//  bus_wdata out  DATA_W           write data; stable while bus_req
//  bus_ack   in   1                transaction complete; ignored when bus_req=0
//  bus_rdata in   DATA_W           read data, sampled on the bus_ack cycle of a read
//  resp      out  1+ADDR_W+DATA_W  {err, addr, rdata}
//  resp_vld  out  1                response valid; held until resp_rdy
//  resp_rdy  in   1                response accepted when resp_vld&resp_rdy
//  ovf       out  1                sticky: pvld arrived with FIFO full
//  busy      out  1                FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: every output 0, FIFO empty, FSM IDLE, ovf cleared. rst mid-transaction aborts it
//   immediately: no bus_req/resp_vld on the following cycle, and queued commands are discarded.
//  FIFO: push on pvld when not full. pvld while full drops the word and sets ovf.
//   Push and pop in the same cycle are both allowed, including when full; the entry is not
//   dropped in that case.
//  FSM states: IDLE, BUS, RESP.
//  IDLE: if FIFO non-empty, pop the head and register bus_wr=~payload[40], addr and wdata.
//   Assert bus_req the next cycle and go to BUS.
//   A pvld into an empty FIFO yields bus_req 2 cycles after pvld.
//  BUS: hold bus_req until bus_ack. bus_req deasserts the cycle after bus_ack.
//   Write goes to IDLE. Read captures bus_rdata and goes to RESP.
//  RESP: resp_vld=1 with resp={1'b0,addr,rdata}. On resp_vld&resp_rdy go to IDLE.
//   resp_vld drops the next cycle.
//  One transaction in flight at a time, in FIFO order.
//  Writes produce no response word.
//  bus_ack in the same cycle bus_req first rises is valid.
// CONFIGURATION
//  PNB_TIMEOUT_EN defined: 8-bit-min counter runs in BUS and clears on entering BUS.
//   Reaching TIMEOUT_CYC with no bus_ack drops bus_req.
//   A timed-out read goes to RESP with resp={1'b1,addr,{DATA_W{1'b0}}}.
//   A timed-out write goes to IDLE silently.
//  PNB_TIMEOUT_EN undefined: no counter; BUS waits forever; the err bit is always 0.
// TESTING
//  Write: pvld with payload={0,8'h12,32'hDEADBEEF} -> bus_req at +2 with bus_wr=1, addr 12,
//   wdata DEADBEEF; ack at +4 -> req low at +5; no resp_vld.
//  Read: payload={1,8'h34,x}, bus_rdata=32'hCAFE0001 on ack -> resp_vld with
//   resp={0,8'h34,32'hCAFE0001}. Hold resp_rdy=0 for 3 cycles -> resp_vld stays high, resp stable.
//  Overflow: bus_ack tied 0; 6 pvld strobes (FIFO_DEPTH=4) -> 1 in flight, 4 queued, 6th dropped,
//   ovf=1. Then release ack -> exactly 5 bus transactions, in order.
//  Simultaneous: pvld coincides with the IDLE pop while FIFO full -> no drop, ovf stays 0.
//  Reset: assert rst during BUS with 2 queued -> next cycle bus_req=0, busy=0, ovf=0, no stale
//   transactions after release.
//  Timeout (PNB_TIMEOUT_EN, TIMEOUT_CYC=255): read with ack never asserted -> bus_req drops after
//   255 cycles; resp={1,addr,0}; next queued command proceeds.

Source files
------------

// File: rtl/pnb_payload_dispatch.sv
// Payload-to-register-bus dispatcher: FIFO-buffered commands become bus writes or reads + response.
// Optional bus-ack timeout enabled by defining PNB_TIMEOUT_EN.
module pnb_payload_dispatch #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     sck,
    input  logic                     rst,
    input  logic [ADDR_W+DATA_W:0]   payload,
    input  logic                     pvld,
    output logic                     bus_req,
    output logic                     bus_wr,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic [ADDR_W+DATA_W:0]   resp,
    output logic                     resp_vld,
    input  logic                     resp_rdy,
    output logic                     ovf,
    output logic                     busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 1");
    end

    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    state_t        state;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push  = pvld && (!full || pop);
    assign head  = mem[rptr];
    assign busy  = !empty || (state != IDLE);

    always_ff @(posedge sck) begin
        if (push) mem[wptr] <= cmd_t'(payload);
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (pvld && !push) ovf <= 1'b1;
        end
    end

`ifdef PNB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge sck) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            resp      <= '0;
            resp_vld  <= 1'b0;
`ifdef PNB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    bus_wr    <= ~head.rd;
                    bus_addr  <= head.addr;
                    bus_wdata <= head.data;
                    bus_req   <= 1'b1;
                    state     <= BUS;
`ifdef PNB_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_wr) state <= IDLE;
                        else begin
                            resp     <= {1'b0, bus_addr, bus_rdata};
                            resp_vld <= 1'b1;
                            state    <= RESP;
                        end
                    end
`ifdef PNB_TIMEOUT_EN
                    // Last allowed cycle without ack: abandon the transaction.
                    else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        bus_req <= 1'b0;
                        if (bus_wr) state <= IDLE;
                        else begin
                            resp     <= {1'b1, bus_addr, {DATA_W{1'b0}}};
                            resp_vld <= 1'b1;
                            state    <= RESP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: if (resp_rdy) begin
                    resp_vld <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pnb_payload_dispatch.sv
// Bench for pnb_payload_dispatch: table-driven vectors plus hand-written corner sequences,
// with scoreboard queues checked by bus and response monitors.
module tb_pnb_payload_dispatch;
    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic [40:0] payload = '0;
    logic        pvld = 1'b0;
    logic        bus_req, bus_wr;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [40:0] resp;
    logic        resp_vld;
    logic        resp_rdy = 1'b1;
    logic        ovf, busy;

    pnb_payload_dispatch dut (
        .sck(sck), .rst(rst), .payload(payload), .pvld(pvld),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp(resp), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
        .ovf(ovf), .busy(busy)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } bus_t;

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_wr;
        logic        has_resp;
        logic [40:0] exp_resp;
    } vec_t;

    bus_t        bus_q[$];
    logic [40:0] resp_q[$];
    vec_t        vt[6];
    int          total = 0;
    int          bad = 0;
    int          acks = 0;
    int          req_cyc = 0;
    logic        hold_ack = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic send(input logic rd, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int lat, input logic exp_wr,
                        input logic has_resp, input logic [40:0] exp_resp, input logic keep);
        bus_t b;
        payload = {rd, a, wd};
        pvld    = 1'b1;
        if (keep) begin
            b.wr = exp_wr; b.addr = a; b.wdata = wd; b.rdata = rdv; b.lat = lat;
            bus_q.push_back(b);
            if (has_resp) resp_q.push_back(exp_resp);
        end
        tick();
        pvld = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((busy || bus_q.size() != 0 || resp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(nm, 64'(n < budget), 64'd1);
    endtask

    // Bus responder + monitor: acks the head transaction after its latency, checks its fields.
    always @(negedge sck) begin
        if (rst || !bus_req) begin
            bus_ack = 1'b0;
            req_cyc = 0;
        end else begin
            if (bus_q.size() == 0) begin
                if (req_cyc == 0) check("bus_unexpected", 64'd1, 64'd0);
                bus_ack = 1'b0;
            end else if (!hold_ack && req_cyc >= bus_q[0].lat) begin
                check("bus_txn", {bus_wr, bus_addr, bus_wdata},
                      {bus_q[0].wr, bus_q[0].addr, bus_q[0].wdata});
                bus_rdata = bus_q[0].rdata;
                bus_ack   = 1'b1;
                void'(bus_q.pop_front());
                acks++;
            end else begin
                bus_ack = 1'b0;
            end
            req_cyc++;
        end
    end

    always @(negedge sck) begin
        if (!rst && resp_vld && resp_rdy) begin
            if (resp_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
            else check("resp_word", resp, resp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        logic seen;

        vt[0] = '{1'b0, 8'h01, 32'h11111111, 32'h0,        0, 1'b1, 1'b0, 41'h0};
        vt[1] = '{1'b1, 8'h02, 32'h0,        32'hA0A0A0A0, 0, 1'b0, 1'b1, {1'b0, 8'h02, 32'hA0A0A0A0}};
        vt[2] = '{1'b1, 8'hFF, 32'h5555AAAA, 32'hFFFFFFFF, 3, 1'b0, 1'b1, {1'b0, 8'hFF, 32'hFFFFFFFF}};
        vt[3] = '{1'b0, 8'h00, 32'hFFFFFFFF, 32'h0,        1, 1'b1, 1'b0, 41'h0};
        vt[4] = '{1'b1, 8'h80, 32'h0,        32'h00000001, 2, 1'b0, 1'b1, {1'b0, 8'h80, 32'h00000001}};
        vt[5] = '{1'b0, 8'h7E, 32'h80000000, 32'h0,        3, 1'b1, 1'b0, 41'h0};

        // Reset state
        tick(); tick();
        check("reset_outs", {bus_req, bus_wr, bus_addr, bus_wdata, resp_vld, ovf, busy}, 64'd0);
        check("reset_resp", resp, 64'd0);
        rst = 1'b0;
        tick();

        // Single write: bus_req at +2, ack at +4, req low at +5, no response
        send(1'b0, 8'h12, 32'hDEADBEEF, 32'h0, 2, 1'b1, 1'b0, 41'h0, 1'b1);
        check("wr_req_plus1", bus_req, 64'd0);
        tick();
        check("wr_req_plus2", {bus_req, bus_wr, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h12, 32'hDEADBEEF});
        tick(); tick();
        check("wr_req_plus4", bus_req, 64'd1);
        tick();
        check("wr_req_plus5", {bus_req, resp_vld}, 64'd0);
        wait_idle("wr_drain", 20);

        // Read with response held off for 3 cycles
        resp_rdy = 1'b0;
        send(1'b1, 8'h34, 32'h0, 32'hCAFE0001, 1, 1'b0, 1'b1, {1'b0, 8'h34, 32'hCAFE0001}, 1'b1);
        n = 0;
        while (!resp_vld && n < 20) begin tick(); n++; end
        check("rd_resp_seen", 64'(n < 20), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("rd_hold", {resp_vld, resp}, {1'b1, 1'b0, 8'h34, 32'hCAFE0001});
            tick();
        end
        resp_rdy = 1'b1;
        tick();
        check("rd_vld_drop", resp_vld, 64'd0);
        wait_idle("rd_drain", 20);

        // Table-driven mixed traffic
        a0 = acks;
        for (int i = 0; i < 6; i++) begin
            send(vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].lat,
                 vt[i].exp_wr, vt[i].has_resp, vt[i].exp_resp, 1'b1);
            repeat (3) tick();
        end
        wait_idle("tbl_drain", 200);
        check("tbl_acks", 64'(acks - a0), 64'd6);
        check("tbl_ovf", ovf, 64'd0);

        // Overflow: 1 in flight, 4 queued, 6th dropped
        hold_ack = 1'b1;
        a0 = acks;
        for (int i = 0; i < 6; i++)
            send(1'b0, 8'(8'h40 + i), 32'(32'h1111 * (i + 1)), 32'h0, 0, 1'b1, 1'b0, 41'h0, 1'(i < 5));
        check("ovf_set", {ovf, busy}, 64'd3);
        hold_ack = 1'b0;
        wait_idle("ovf_drain", 100);
        check("ovf_txns", 64'(acks - a0), 64'd5);
        check("ovf_sticky", ovf, 64'd1);

        // Reset mid-transaction with 2 queued
        hold_ack = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1'b0, 8'(8'h60 + i), 32'(i), 32'h0, 0, 1'b1, 1'b0, 41'h0, 1'b1);
        check("rst_pre_req", bus_req, 64'd1);
        rst = 1'b1;
        bus_q.delete();
        resp_q.delete();
        tick();
        check("rst_abort", {bus_req, resp_vld, busy, ovf}, 64'd0);
        rst = 1'b0;
        hold_ack = 1'b0;
        a0 = acks;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_req || busy) seen = 1'b1;
        end
        check("rst_no_stale", {seen, 32'(acks - a0)}, 64'd0);

        // Push while full coinciding with the IDLE pop: nothing dropped
        hold_ack = 1'b1;
        a0 = acks;
        for (int i = 0; i < 5; i++)
            send(1'b0, 8'(8'h50 + i), 32'(32'hA000 + i), 32'h0, 0, 1'b1, 1'b0, 41'h0, 1'b1);
        hold_ack = 1'b0;
        n = 0;
        while (bus_req && n < 10) begin tick(); n++; end
        check("sim_idle_seen", 64'(n < 10), 64'd1);
        send(1'b0, 8'h55, 32'hA005, 32'h0, 0, 1'b1, 1'b0, 41'h0, 1'b1);
        check("sim_no_ovf", ovf, 64'd0);
        wait_idle("sim_drain", 100);
        check("sim_txns", 64'(acks - a0), 64'd6);
        check("sim_ovf_end", ovf, 64'd0);

`ifdef PNB_TIMEOUT_EN
        // Timed-out read yields an error response, then the queued write proceeds
        hold_ack  = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        a0 = acks;
        send(1'b1, 8'h77, 32'h0, 32'h0, 0, 1'b0, 1'b1, {1'b1, 8'h77, 32'h0}, 1'b1);
        send(1'b0, 8'h78, 32'h12345678, 32'h0, 0, 1'b1, 1'b0, 41'h0, 1'b1);
        n = 0;
        while (!bus_req && n < 5) begin tick(); n++; end
        check("to_req_seen", 64'(n < 5), 64'd1);
        n = 0;
        while (bus_req && n < 400) begin tick(); n++; end
        check("to_len", 64'(n), 64'd255);
        void'(bus_q.pop_front());
        hold_ack = 1'b0;
        wait_idle("to_drain", 50);
        check("to_next_txn", 64'(acks - a0), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
